// File: rtl/tt_mask_idx_arb_if.sv
// -----------------------------------------------------------------------------
// tt_mask_idx_arb_if
//   Bundles the item channel of tt_mask_idx_arb: the two upstream producer
//   push/credit paths, the downstream credited item path and the error flag.
//   master : producer/consumer side (drives pushes and downstream credits)
//   slave  : arbiter side (drives credits back upstream and downstream items)
// Signals
//   i_req_valid  [1:0]         per-requester item push
//   i_req_item   [2*ITEM_W-1:0] per-requester item, [ITEM_W-1:0] is req 0
//   i_req_last   [1:0]         pushed item is last of its memop
//   o_req_credit [1:0]         one-cycle credit return pulse per requester
//   o_dn_valid                 downstream item valid
//   o_dn_item    [ITEM_W-1:0]  downstream item
//   o_dn_last                  downstream last-of-memop flag
//   o_dn_src                   requester id of o_dn_item
//   i_dn_credit                downstream credit return pulse
//   o_err                      sticky protocol error
// -----------------------------------------------------------------------------
interface tt_mask_idx_arb_if #(
  parameter int ITEM_W = 65
);
  logic [1:0]          i_req_valid;
  logic [2*ITEM_W-1:0] i_req_item;
  logic [1:0]          i_req_last;
  logic [1:0]          o_req_credit;
  logic                o_dn_valid;
  logic [ITEM_W-1:0]   o_dn_item;
  logic                o_dn_last;
  logic                o_dn_src;
  logic                i_dn_credit;
  logic                o_err;

  modport master (
    output i_req_valid, i_req_item, i_req_last, i_dn_credit,
    input  o_req_credit, o_dn_valid, o_dn_item, o_dn_last, o_dn_src, o_err
  );

  modport slave (
    input  i_req_valid, i_req_item, i_req_last, i_dn_credit,
    output o_req_credit, o_dn_valid, o_dn_item, o_dn_last, o_dn_src, o_err
  );
endinterface

// File: rtl/tt_mask_idx_arb.sv
// -----------------------------------------------------------------------------
// tt_mask_idx_arb
//   Shares one credited mask/index item channel into the LSU between two
//   producers (req 0 = load pipe, req 1 = store pipe). Each requester's items
//   sit in a private FIFO; one upstream credit is returned per item consumed.
//   Arbitration is round-robin but locked per memop: the winner keeps the
//   channel until its last-index item issues.
// Ports
//   i_clk    clock
//   i_reset  asynchronous reset, active-high
//   bus      tt_mask_idx_arb_if.slave (request pushes, credits, downstream)
// Configuration
//   TT_MASK_IDX_ARB_CHK_EN : when defined, o_err sets (sticky) on a push into
//   a full FIFO or on a downstream credit while all credits are held, and a
//   simulation-only $error is printed per event. When undefined, o_err is 0.
// -----------------------------------------------------------------------------
module tt_mask_idx_arb #(
  parameter int REQ_DEPTH  = 2,
  parameter int DN_CREDITS = 2,
  parameter int ITEM_W     = 65
) (
  input  logic              i_clk,
  input  logic              i_reset,
  tt_mask_idx_arb_if.slave  bus
);
  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(REQ_DEPTH + 1);
  localparam int CRD_W = $clog2(DN_CREDITS + 1);
  localparam int ENT_W = ITEM_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(REQ_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REQ_DEPTH);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(DN_CREDITS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic [ENT_W-1:0]  mem_q [2][REQ_DEPTH];
  logic [ENT_W-1:0]  mem_d [2][REQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];
  logic [CRD_W-1:0]  crd_q, crd_d;
  logic              dn_valid_q, dn_valid_d;
  logic [ITEM_W-1:0] dn_item_q, dn_item_d;
  logic              dn_last_q, dn_last_d;
  logic              dn_src_q, dn_src_d;
  logic [1:0]        req_credit_q, req_credit_d;

  logic [1:0]        nonempty_s, full_s, push_s, pop_s;
  logic              have_s, sel_s, issue_s;
  logic [ENT_W-1:0]  head_s;

  // Circular pointer advance that also handles non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // FIFO status flags; a push into a full FIFO is dropped even if it pops.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      nonempty_s[r] = (cnt_q[r] != '0);
      full_s[r]     = (cnt_q[r] == CNT_FULL);
      push_s[r]     = bus.i_req_valid[r] & ~full_s[r];
    end
  end

  // Requester selection, issue decision and lock/round-robin next state.
  always_comb begin
    sel_s   = rr_q;
    have_s  = 1'b0;
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (nonempty_s[rr_q]) begin
          sel_s  = rr_q;
          have_s = 1'b1;
        end else if (nonempty_s[~rr_q]) begin
          sel_s  = ~rr_q;
          have_s = 1'b1;
        end else begin
          sel_s  = rr_q;
          have_s = 1'b0;
        end
      end
      ST_LOCKED: begin
        // The other requester waits even with items and credits available.
        sel_s  = owner_q;
        have_s = nonempty_s[owner_q];
      end
      default: begin
        sel_s  = rr_q;
        have_s = 1'b0;
      end
    endcase
    head_s  = mem_q[sel_s][rd_ptr_q[sel_s]];
    // A same-cycle downstream credit is not used to enable issue.
    issue_s = have_s && (crd_q != '0);
    if (issue_s) begin
      if (head_s[ITEM_W]) begin
        state_d = ST_IDLE;
        rr_d    = ~sel_s;
      end else begin
        state_d = ST_LOCKED;
        owner_d = sel_s;
      end
    end else begin
      state_d = state_q;
    end
    pop_s = issue_s ? (sel_s ? 2'b10 : 2'b01) : 2'b00;
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    for (int r = 0; r < 2; r++) begin
      wr_ptr_d[r] = wr_ptr_q[r];
      rd_ptr_d[r] = rd_ptr_q[r];
      cnt_d[r]    = cnt_q[r];
      if (push_s[r]) begin
        mem_d[r][wr_ptr_q[r]] = {bus.i_req_last[r], bus.i_req_item[r*ITEM_W +: ITEM_W]};
        wr_ptr_d[r]           = ptr_inc(wr_ptr_q[r]);
      end else begin
        wr_ptr_d[r] = wr_ptr_q[r];
      end
      if (pop_s[r]) begin
        rd_ptr_d[r] = ptr_inc(rd_ptr_q[r]);
      end else begin
        rd_ptr_d[r] = rd_ptr_q[r];
      end
      case ({push_s[r], pop_s[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + CNT_W'(1);
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_W'(1);
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  // Downstream credit counter; a credit arriving while full is discarded.
  always_comb begin
    crd_d = crd_q;
    case ({bus.i_dn_credit, issue_s})
      2'b10:   crd_d = (crd_q == CRD_MAX) ? crd_q : crd_q + CRD_W'(1);
      2'b01:   crd_d = crd_q - CRD_W'(1);
      default: crd_d = crd_q;
    endcase
  end

  // Output register contents; data holds when nothing issues.
  always_comb begin
    dn_valid_d   = issue_s;
    req_credit_d = pop_s;
    if (issue_s) begin
      dn_item_d = head_s[ITEM_W-1:0];
      dn_last_d = head_s[ITEM_W];
      dn_src_d  = sel_s;
    end else begin
      dn_item_d = dn_item_q;
      dn_last_d = dn_last_q;
      dn_src_d  = dn_src_q;
    end
  end

  // State, FIFO and output flops; reset discards lock, contents and credits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      rr_q         <= 1'b0;
      owner_q      <= 1'b0;
      crd_q        <= CRD_MAX;
      dn_valid_q   <= 1'b0;
      dn_item_q    <= '0;
      dn_last_q    <= 1'b0;
      dn_src_q     <= 1'b0;
      req_credit_q <= 2'b00;
      for (int r = 0; r < 2; r++) begin
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        cnt_q[r]    <= '0;
        for (int i = 0; i < REQ_DEPTH; i++) begin
          mem_q[r][i] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      crd_q        <= crd_d;
      dn_valid_q   <= dn_valid_d;
      dn_item_q    <= dn_item_d;
      dn_last_q    <= dn_last_d;
      dn_src_q     <= dn_src_d;
      req_credit_q <= req_credit_d;
      mem_q        <= mem_d;
      for (int r = 0; r < 2; r++) begin
        wr_ptr_q[r] <= wr_ptr_d[r];
        rd_ptr_q[r] <= rd_ptr_d[r];
        cnt_q[r]    <= cnt_d[r];
      end
    end
  end

  assign bus.o_dn_valid   = dn_valid_q;
  assign bus.o_dn_item    = dn_item_q;
  assign bus.o_dn_last    = dn_last_q;
  assign bus.o_dn_src     = dn_src_q;
  assign bus.o_req_credit = req_credit_q;

`ifdef TT_MASK_IDX_ARB_CHK_EN
  logic err_q, err_d;

  // Sticky protocol-error flag: FIFO overflow or surplus downstream credit.
  always_comb begin
    err_d = err_q | (|(bus.i_req_valid & full_s)) |
            (bus.i_dn_credit & (crd_q == CRD_MAX));
  end

  // Error flag register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.o_err = err_q;

`ifndef SYNTHESIS
  // Simulation-only report of each protocol error event.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (|(bus.i_req_valid & full_s)) begin
        $error("tt_mask_idx_arb: push into full FIFO dropped (valid=%b full=%b)",
               bus.i_req_valid, full_s);
      end
      if (bus.i_dn_credit && (crd_q == CRD_MAX)) begin
        $error("tt_mask_idx_arb: downstream credit dropped at full credit count");
      end
    end
  end
`endif
`else
  assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_mask_idx_arb.sv
// Self-checking bench for tt_mask_idx_arb: directed memop scenarios followed
// by randomized traffic, every cycle compared against a queue-based model.
module tb_tt_mask_idx_arb;
  localparam int REQ_DEPTH  = 2;
  localparam int DN_CREDITS = 2;
  localparam int ITEM_W     = 65;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tt_mask_idx_arb_if #(.ITEM_W(ITEM_W)) bus ();

  tt_mask_idx_arb #(
    .REQ_DEPTH (REQ_DEPTH),
    .DN_CREDITS(DN_CREDITS),
    .ITEM_W    (ITEM_W)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [ITEM_W-1:0] obs,
                           input logic [ITEM_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Reference model: one queue per requester plus arbitration bookkeeping.
  logic [ITEM_W:0]   mq [2][$];
  int                m_crd;
  bit                m_locked;
  int                m_owner;
  int                m_rr;
  logic              e_valid, e_last, e_src, e_err;
  logic [1:0]        e_credit;
  logic [ITEM_W-1:0] e_item;
  int                outstanding;
  bit                auto_credit;
  int                n_obs_valid;
  int                src_log[$];

`ifdef TT_MASK_IDX_ARB_CHK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  task automatic model_reset();
    mq[0].delete();
    mq[1].delete();
    m_crd = DN_CREDITS; m_locked = 1'b0; m_owner = 0; m_rr = 0;
    e_valid = 1'b0; e_last = 1'b0; e_src = 1'b0; e_err = 1'b0;
    e_credit = 2'b00; e_item = '0; outstanding = 0;
  endtask

  function automatic logic [ITEM_W-1:0] rnd_item();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[ITEM_W-1:0];
  endfunction

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input logic [1:0] v, input logic [ITEM_W-1:0] it0,
                       input logic [ITEM_W-1:0] it1, input logic [1:0] lst,
                       input logic dc);
    int sel;
    bit issued;
    bit [1:0] pre_full;
    int pre_crd;
    logic [ITEM_W:0] head;
    bus.i_req_valid = v;
    bus.i_req_item  = {it1, it0};
    bus.i_req_last  = lst;
    bus.i_dn_credit = dc;
    for (int r = 0; r < 2; r++) pre_full[r] = (mq[r].size() >= REQ_DEPTH);
    pre_crd = m_crd;
    sel = -1;
    if (m_locked) begin
      if (mq[m_owner].size() > 0) sel = m_owner;
    end else if (mq[m_rr].size() > 0) sel = m_rr;
    else if (mq[1-m_rr].size() > 0) sel = 1 - m_rr;
    issued = (sel >= 0) && (m_crd > 0);
    e_valid = 1'b0;
    e_credit = 2'b00;
    if (issued) begin
      head = mq[sel].pop_front();
      e_valid = 1'b1;
      e_item = head[ITEM_W-1:0];
      e_last = head[ITEM_W];
      e_src = (sel == 1);
      e_credit[sel] = 1'b1;
      if (head[ITEM_W]) begin m_locked = 1'b0; m_rr = 1 - sel; end
      else begin m_locked = 1'b1; m_owner = sel; end
    end
    for (int r = 0; r < 2; r++) begin
      if (v[r]) begin
        if (!pre_full[r]) mq[r].push_back({lst[r], (r == 0) ? it0 : it1});
        else if (CHK_ON) e_err = 1'b1;
      end
    end
    m_crd = m_crd + int'(dc) - int'(issued);
    if (m_crd > DN_CREDITS) m_crd = DN_CREDITS;
    if (CHK_ON && dc && pre_crd == DN_CREDITS) e_err = 1'b1;
    if (issued) outstanding++;
    if (dc && outstanding > 0) outstanding--;
    @(posedge clk);
    #1;
    check_val("dn_valid", ITEM_W'(bus.o_dn_valid), ITEM_W'(e_valid));
    check_val("req_credit", ITEM_W'(bus.o_req_credit), ITEM_W'(e_credit));
    check_val("dn_item", bus.o_dn_item, e_item);
    check_val("dn_last", ITEM_W'(bus.o_dn_last), ITEM_W'(e_last));
    check_val("dn_src", ITEM_W'(bus.o_dn_src), ITEM_W'(e_src));
    check_val("err", ITEM_W'(bus.o_err), ITEM_W'(e_err));
    if (bus.o_dn_valid) begin
      n_obs_valid++;
      src_log.push_back(int'(bus.o_dn_src));
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [ITEM_W-1:0] it0,
                      input logic [ITEM_W-1:0] it1, input logic [1:0] lst);
    cycle(v, it0, it1, lst, auto_credit && (outstanding > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, 2'b00);
  endtask

  task automatic do_reset();
    bus.i_req_valid = 2'b00; bus.i_req_last = 2'b00;
    bus.i_req_item = '0; bus.i_dn_credit = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    src_log.delete();
    n_obs_valid = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_valid"}, ITEM_W'(bus.o_dn_valid), '0);
    check_val({tag, "_credit"}, ITEM_W'(bus.o_req_credit), '0);
    check_val({tag, "_item"}, bus.o_dn_item, '0);
    check_val({tag, "_last"}, ITEM_W'(bus.o_dn_last), '0);
    check_val({tag, "_src"}, ITEM_W'(bus.o_dn_src), '0);
    check_val({tag, "_err"}, ITEM_W'(bus.o_err), '0);
  endtask

  initial begin
    logic [ITEM_W-1:0] a, b;
    logic [1:0] v, l;
    bus.i_req_valid = 2'b00; bus.i_req_last = 2'b00;
    bus.i_req_item = '0; bus.i_dn_credit = 1'b0;
    model_reset();
    auto_credit = 1'b1;
    n_obs_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Single memop from req 0: two items, last on the second.
    a = rnd_item(); b = rnd_item();
    step(2'b01, a, '0, 2'b00);
    step(2'b01, b, '0, 2'b01);
    idle(3);
    check_val("single_count", ITEM_W'(n_obs_valid), ITEM_W'(2));

    // Lock: req 1 pushes mid-memop but waits for req 0's last item.
    do_reset();
    step(2'b01, rnd_item(), '0, 2'b00);
    step(2'b11, rnd_item(), rnd_item(), 2'b10);
    step(2'b01, rnd_item(), '0, 2'b01);
    idle(6);
    check_val("lock_count", ITEM_W'(src_log.size()), ITEM_W'(4));
    for (int i = 0; i < 4 && i < src_log.size(); i++)
      check_val("lock_src", ITEM_W'(src_log[i]), ITEM_W'((i == 3) ? 1 : 0));

    // Round-robin: single-item memops from both requesters.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v[0] = (mq[0].size() < REQ_DEPTH);
      v[1] = (mq[1].size() < REQ_DEPTH);
      step(v, rnd_item(), rnd_item(), 2'b11);
    end
    idle(6);
    check_val("rr_count_ge6", ITEM_W'(src_log.size() >= 6), ITEM_W'(1));
    for (int i = 0; i < 6 && i < src_log.size(); i++)
      check_val("rr_src", ITEM_W'(src_log[i]), ITEM_W'(i % 2));

    // Credit stall: no downstream credits returned.
    do_reset();
    auto_credit = 1'b0;
    for (int i = 0; i < 4; i++) step(2'b01, rnd_item(), '0, (i == 3) ? 2'b01 : 2'b00);
    idle(4);
    check_val("stall_count", ITEM_W'(n_obs_valid), ITEM_W'(2));
    cycle(2'b00, '0, '0, 2'b00, 1'b1);
    idle(3);
    check_val("stall_resume", ITEM_W'(n_obs_valid), ITEM_W'(3));

    // Overflow: req 1 pushes three items with no downstream credit left.
    for (int i = 0; i < 3; i++) step(2'b10, '0, rnd_item(), 2'b00);
    idle(1);
    check_val("ovf_err", ITEM_W'(bus.o_err), ITEM_W'(CHK_ON));
    idle(2);

    // Asynchronous reset in the middle of a locked memop.
    do_reset();
    auto_credit = 1'b1;
    step(2'b01, rnd_item(), '0, 2'b00);
    step(2'b01, rnd_item(), '0, 2'b00);
    bus.i_req_valid = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    src_log.delete();
    n_obs_valid = 0;
    step(2'b10, '0, rnd_item(), 2'b10);
    idle(3);
    check_val("post_rst_count", ITEM_W'(src_log.size()), ITEM_W'(1));
    if (src_log.size() > 0) check_val("post_rst_src", ITEM_W'(src_log[0]), ITEM_W'(1));

    // Randomized traffic with a randomly returning consumer.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      v[0] = ($urandom_range(0, 1) == 1) && (mq[0].size() < REQ_DEPTH);
      v[1] = ($urandom_range(0, 1) == 1) && (mq[1].size() < REQ_DEPTH);
      l[0] = ($urandom_range(0, 2) == 0);
      l[1] = ($urandom_range(0, 2) == 0);
      cycle(v, rnd_item(), rnd_item(), l,
            (outstanding > 0) && ($urandom_range(0, 1) == 1));
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
